// File: rtl/fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit_pkg
// Brief   : Shared fetch-stage state encodings and PC step constant.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
//------------------------------------------------------------------------------
// Module  : pc_next
// Brief   : Combinational next-PC select: jr over jump over sequential.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_next (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_next
);

    // Low bits of the register target and the lower PC bits replaced by a
    // J-type index are intentionally dropped.
    logic w_unused_bits;
    assign w_unused_bits = ^{jr_target[1:0], pc_plus4[27:0]};

    always_comb begin
        pc_next = pc_plus4;
        if (jr) begin
            pc_next = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            pc_next = {pc_plus4[31:28], instr_index, 2'b00};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : Instruction fetch stage: PC, imem handshake, instruction latch.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [5:0]  op_o,
    output logic [5:0]  funct_o,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_pc_next;

    assign w_pc_plus4 = pc_q + PC_STEP;

    pc_next u_pc_next (
        .pc_plus4    (w_pc_plus4),
        .instr_index (instr_q[25:0]),
        .jump        (jump),
        .jr          (jr),
        .jr_target   (jr_target),
        .pc_next     (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_FETCH;
            end
            FS_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = FS_HOLD;
                end
            end
            FS_HOLD: begin
                instr_valid = 1'b1;
                // Decoder jump/jr are only meaningful in the ack cycle.
                if (instr_ack) begin
                    pc_d    = w_pc_next;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = FS_FETCH;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign instr_o    = instr_q;
    assign op_o       = instr_q[31:26];
    assign funct_o    = instr_q[5:0];
    assign pc_o       = pc_q;
    assign pc_plus4_o = w_pc_plus4;
    assign instr_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit against a behavioural PC model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_o;
    logic [5:0]  op_o;
    logic [5:0]  funct_o;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_o     (instr_o),
        .op_o        (op_o),
        .funct_o     (funct_o),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .jump        (jump),
        .jr          (jr),
        .jr_target   (jr_target),
        .pc_o        (pc_o),
        .pc_plus4_o  (pc_plus4_o),
        .instr_cnt   (instr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference next-PC, written straight from the MIPS jump rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic j, input logic r, input logic [31:0] t);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (r)      return t & 32'hFFFF_FFFC;
        else if (j) return {seq[31:28], word[25:0], 2'b00};
        else        return seq;
    endfunction

    // One full transaction starting in FETCH: wait states, hold cycles, ack.
    task automatic do_fetch(input int waits, input logic [31:0] word, input int holds,
                            input logic j, input logic r, input logic [31:0] t);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, exp_pc);
        end
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            instr_ack  = 1'($urandom);
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_state: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                         imem_req, imem_addr, instr_valid, exp_pc);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        instr_ack  = 1'($urandom);
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_o !== word || op_o !== word[31:26] ||
            funct_o !== word[5:0] || pc_o !== exp_pc || pc_plus4_o !== exp_pc + 32'd4 ||
            instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL hold_entry: valid=%b req=%b instr=%h op=%h funct=%h pc=%h pc4=%h cnt=%0d required valid=1 req=0 instr=%h pc=%h cnt=%0d",
                     instr_valid, imem_req, instr_o, op_o, funct_o, pc_o, pc_plus4_o, instr_cnt,
                     word, exp_pc, exp_cnt);
        end
        for (int h = 0; h < holds; h++) begin
            instr_ack  = 1'b0;
            jump       = 1'($urandom);
            jr         = 1'($urandom);
            jr_target  = $urandom;
            imem_ready = 1'($urandom);
            tick();
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_o !== word || pc_o !== exp_pc ||
                instr_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL hold_stall: valid=%b req=%b instr=%h pc=%h cnt=%0d required valid=1 req=0 instr=%h pc=%h cnt=%0d",
                         instr_valid, imem_req, instr_o, pc_o, instr_cnt, word, exp_pc, exp_cnt);
            end
        end
        imem_ready = 1'b0;
        instr_ack  = 1'b1;
        jump       = j;
        jr         = r;
        jr_target  = t;
        tick();
        exp_pc  = model_next(exp_pc, word, j, r, t);
        exp_cnt = exp_cnt + 32'd1;
        jump    = 1'b0;
        jr      = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0 || instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL after_ack: req=%b addr=%h valid=%b cnt=%0d required req=1 addr=%h valid=0 cnt=%0d",
                     imem_req, imem_addr, instr_valid, instr_cnt, exp_pc, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready = 1'b1;
        instr_ack  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        imem_ready = 1'b0;
        instr_ack  = 1'b0;
        exp_pc  = 32'd0;
        exp_cnt = 32'd0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_o !== 32'd0 || pc_o !== 32'd0 ||
            instr_cnt !== 32'd0 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h cnt=%0d required all zero",
                     imem_req, instr_valid, instr_o, pc_o, instr_cnt);
        end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            do_fetch(0, $urandom & 32'hF3FF_FFFF, 0, 1'b0, 1'b0, 32'd0);
        end
        checks++;
        if (imem_addr !== 32'h0000_000C || instr_cnt !== 32'd3) begin
            errors++;
            $display("FAIL sequential: addr=%h cnt=%0d required addr=0000000c cnt=3", imem_addr, instr_cnt);
        end
    endtask

    task automatic test_wait_states();
        do_fetch(3, $urandom, 0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_jump();
        do_fetch(0, $urandom, 0, 1'b0, 1'b1, 32'h0040_0010);
        do_fetch(1, 32'h0810_0000, 1, 1'b1, 1'b0, 32'd0);
        checks++;
        if (imem_addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL jump_target: addr=%h required 00400000", imem_addr);
        end
    endtask

    task automatic test_jr_priority();
        do_fetch(0, $urandom, 0, 1'b1, 1'b1, 32'h0000_1237);
        checks++;
        if (imem_addr !== 32'h0000_1234) begin
            errors++;
            $display("FAIL jr_priority: addr=%h required 00001234", imem_addr);
        end
    endtask

    task automatic test_stall_wrap();
        do_fetch(0, $urandom, 5, 1'b0, 1'b1, 32'hFFFF_FFFF);
        do_fetch(0, $urandom, 2, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_wrap: addr=%h required 00000000", imem_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
        end
    endtask

    task automatic test_reset_mid();
        // Reset during HOLD with a pending ack.
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        imem_ready = 1'b0;
        instr_ack  = 1'b1;
        jump       = 1'b1;
        rst        = 1'b1;
        tick();
        exp_pc  = 32'd0;
        exp_cnt = 32'd0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_o !== 32'd0 || instr_cnt !== 32'd0 ||
            instr_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b req=%b pc=%h cnt=%0d instr=%h required all zero",
                     instr_valid, imem_req, pc_o, instr_cnt, instr_o);
        end
        rst       = 1'b0;
        instr_ack = 1'b0;
        jump      = 1'b0;
        tick();
        do_fetch(0, $urandom, 0, 1'b0, 1'b0, 32'd0);
        // Reset during FETCH with memory answering in the same cycle.
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst        = 1'b1;
        tick();
        imem_ready = 1'b0;
        rst        = 1'b0;
        exp_pc  = 32'd0;
        exp_cnt = 32'd0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_o !== 32'd0 || pc_o !== 32'd0 ||
            instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_fetch: valid=%b req=%b instr=%h pc=%h cnt=%0d required all zero",
                     instr_valid, imem_req, instr_o, pc_o, instr_cnt);
        end
        tick();
        do_fetch(0, $urandom, 0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_wait_states();
        test_jump();
        test_jr_priority();
        test_stall_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
